// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 MAC sequencer.
// Slice is configured B_INPUT=DIRECT, CARRYINSEL=OPMODE5, so OPMODE[6:4] stay zero.
package dsp_mac_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int         OPM_SUB_BIT   = 7;
    localparam logic [7:0] OPM_FIRST_ADD = 8'h01;  // Z=0, X=M
    localparam logic [7:0] OPM_ACC_ADD   = 8'h09;  // Z=P, X=M
    localparam logic [7:0] OPM_HOLD      = 8'h08;  // Z=P, X=0
    localparam logic [7:0] OPM_CLR       = 8'h00;

    function automatic logic [7:0] opm_beat(input logic first, input logic sub);
        logic [7:0] o;
        o              = first ? OPM_FIRST_ADD : OPM_ACC_ADD;
        o[OPM_SUB_BIT] = sub;
        return o;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Command, operand-stream and result handshakes of the MAC sequencer.
// master = fetch/consumer side, slave = sequencer.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_sub;
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      in_a;
    logic [17:0]      in_b;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_data;

    modport master (
        output cmd_valid, cmd_len, cmd_sub, in_valid, in_a, in_b, res_ready,
        input  cmd_ready, in_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_sub, in_valid, in_a, in_b, res_ready,
        output cmd_ready, in_ready, res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_sequencer_opmode_delay_line.sv
// Fixed-depth shift register that aligns the issued OPMODE tag with the slice pipeline.
// DEPTH=0 degenerates to a wire.
module opmode_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] sr;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sr <= '0;
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end
            assign q = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams operand pairs into a DSP48A1 slice as a dot product and returns the drained P.
// Stalls are bubbles of HOLD opcodes; the slice clock enable only drops during reset.
module dsp_mac_sequencer
    import dsp_mac_pkg::*;
#(
    parameter int LEN_W   = 10,
    parameter int P_LAT   = 3,
    parameter int OPM_DLY = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    dsp_mac_sequencer_if.slave   bus,
    output logic [17:0]          DSP_A,
    output logic [17:0]          DSP_B,
    output logic [7:0]           DSP_OPMODE,
    output logic                 DSP_CE,
    input  logic [47:0]          DSP_P
);
    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;   // beat index in RUN, drain countdown in DRAIN
    logic             sub_q;
    logic [7:0]       tag_q; // issued tag, aligned with DSP_A/DSP_B

    wire cmd_hs = bus.cmd_valid & bus.cmd_ready;
    wire in_hs  = bus.in_valid & bus.in_ready;

    assign DSP_CE = ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            len_q         <= '0;
            cnt           <= '0;
            sub_q         <= 1'b0;
            tag_q         <= OPM_CLR;
            DSP_A         <= '0;
            DSP_B         <= '0;
            bus.cmd_ready <= 1'b1;
            bus.in_ready  <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
        end else begin
            tag_q <= OPM_HOLD;
            DSP_A <= '0;
            DSP_B <= '0;
            case (state)
                S_IDLE: if (cmd_hs) begin
                    len_q         <= bus.cmd_len;
                    sub_q         <= bus.cmd_sub;
                    cnt           <= '0;
                    bus.cmd_ready <= 1'b0;
                    if (bus.cmd_len == '0) begin
                        state         <= S_DONE;
                        bus.res_data  <= '0;
                        bus.res_valid <= 1'b1;
                    end else begin
                        state        <= S_RUN;
                        bus.in_ready <= 1'b1;
                    end
                end
                S_RUN: if (in_hs) begin
                    DSP_A <= bus.in_a;
                    DSP_B <= bus.in_b;
                    tag_q <= opm_beat(cnt == '0, sub_q);
                    if (cnt == len_q - 1'b1) begin
                        state        <= S_DRAIN;
                        cnt          <= LEN_W'(P_LAT);
                        bus.in_ready <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // cnt hits zero exactly when the last beat's sum sits on DSP_P
                S_DRAIN: if (cnt == '0) begin
                    bus.res_data  <= DSP_P;
                    bus.res_valid <= 1'b1;
                    state         <= S_DONE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                S_DONE: if (bus.res_valid & bus.res_ready) begin
                    bus.res_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    opmode_delay_line #(
        .DEPTH (OPM_DLY),
        .WIDTH (8)
    ) u_opm_dly (
        .clk (CLK),
        .rst (RST),
        .d   (tag_q),
        .q   (DSP_OPMODE)
    );
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice model, directed dot products,
// queued expectations for operands, OPMODE timing and results.
module tb_dsp_mac_sequencer;
    localparam int LEN_W   = 10;
    localparam int P_LAT   = 3;
    localparam int OPM_DLY = 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [17:0] DSP_A, DSP_B;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_CE;
    logic [47:0] DSP_P;

    dsp_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

    dsp_mac_sequencer #(
        .LEN_W   (LEN_W),
        .P_LAT   (P_LAT),
        .OPM_DLY (OPM_DLY)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus.slave),
        .DSP_A      (DSP_A),
        .DSP_B      (DSP_B),
        .DSP_OPMODE (DSP_OPMODE),
        .DSP_CE     (DSP_CE),
        .DSP_P      (DSP_P)
    );

    always #5 CLK = ~CLK;

    // Slice model: A1REG/B1REG -> MREG -> PREG, OPMODEREG one stage behind the operands.
    logic [17:0] a1 = '0, b1 = '0;
    logic [35:0] m = '0;
    logic [7:0]  opm_r = '0;
    logic [47:0] p = '0;

    function automatic logic [47:0] slice_next(input logic [47:0] pv, input logic [35:0] mv,
                                               input logic [7:0] opm);
        logic [47:0] x, z;
        x = (opm[1:0] == 2'b01) ? {12'b0, mv} : 48'd0;
        z = (opm[3:2] == 2'b10) ? pv : 48'd0;
        return opm[7] ? z - x : z + x;
    endfunction

    always @(posedge CLK) if (DSP_CE) begin
        a1    <= DSP_A;
        b1    <= DSP_B;
        m     <= a1 * b1;
        opm_r <= DSP_OPMODE;
        p     <= slice_next(p, m, opm_r);
    end
    assign DSP_P = p;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    typedef struct { int c; logic [17:0] a; logic [17:0] b; } a_ev_t;
    typedef struct { int c; logic [7:0] v; } o_ev_t;
    a_ev_t       a_q[$];
    o_ev_t       o_q[$];
    logic [47:0] res_q[$];
    int          exp_vld_cyc = -1;
    logic        prev_rv = 1'b0;

    // Trace and result monitors, sampled mid-cycle.
    always @(negedge CLK) begin
        if (a_q.size() > 0 && a_q[0].c == cyc) begin
            chk("dsp_a", DSP_A, a_q[0].a);
            chk("dsp_b", DSP_B, a_q[0].b);
            void'(a_q.pop_front());
        end
        if (o_q.size() > 0 && o_q[0].c == cyc) begin
            chk("dsp_opmode", DSP_OPMODE, o_q[0].v);
            void'(o_q.pop_front());
        end
        if (bus.res_valid && !prev_rv && exp_vld_cyc >= 0) begin
            chk("res_valid_cycle", cyc, exp_vld_cyc);
            exp_vld_cyc = -1;
        end
        if (bus.res_valid && bus.res_ready) begin
            if (res_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h want none", bus.res_data);
            end else begin
                chk("res_data", bus.res_data, res_q[0]);
                void'(res_q.pop_front());
            end
        end
        prev_rv = bus.res_valid;
    end

    logic [17:0] va[4];
    logic [17:0] vb[4];

    task automatic send_cmd(input logic [LEN_W-1:0] len, input logic sub, output int acc_c);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = len;
        bus.cmd_sub   = sub;
        acc_c         = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (bus.cmd_ready) begin
                acc_c = cyc;
                break;
            end
        end
        if (acc_c < 0) fail_now("cmd_accept");
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input int gap,
                             output int acc_c);
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            if (bus.in_ready) o_q.push_back('{cyc + 1 + OPM_DLY, 8'h08});
            @(posedge CLK); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        acc_c        = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (bus.in_ready) begin
                acc_c = cyc;
                break;
            end
        end
        if (acc_c < 0) fail_now("beat_accept");
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_dot(input int n, input logic sub, input int gap,
                           input logic [47:0] exp, output int cmd_c);
        int c;
        res_q.push_back(exp);
        send_cmd(LEN_W'(n), sub, cmd_c);
        if (n == 0) exp_vld_cyc = cmd_c + 1;
        for (int i = 0; i < n; i++) begin
            send_beat(va[i], vb[i], (i == 0) ? 0 : gap, c);
            a_q.push_back('{c + 1, va[i], vb[i]});
            if (i == 0) o_q.push_back('{c + 1 + OPM_DLY, sub ? 8'h81 : 8'h01});
            else        o_q.push_back('{c + 1 + OPM_DLY, sub ? 8'h89 : 8'h09});
            if (i == n - 1) exp_vld_cyc = c + 2 + P_LAT;
        end
    endtask

    task automatic wait_res();
        int ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (res_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) fail_now("result_wait");
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cc, rel_c, ok;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.cmd_sub   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("ce_in_reset", DSP_CE, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_data", bus.res_data, 48'd0);
        chk("rst_opmode", DSP_OPMODE, 8'h00);
        chk("rst_dsp_a", DSP_A, 18'd0);
        chk("ce_after_reset", DSP_CE, 1'b1);
        @(posedge CLK); #1;

        // Back-to-back add: 2*3 + 4*5 + 1*7 = 33
        va = '{18'd2, 18'd4, 18'd1, 18'd0};
        vb = '{18'd3, 18'd5, 18'd7, 18'd0};
        run_dot(3, 1'b0, 0, 48'd33, cc);
        wait_res();

        // Same with two idle cycles between beats
        run_dot(3, 1'b0, 2, 48'd33, cc);
        wait_res();

        // Subtract: -(3*4) - 1*1 = -13
        va = '{18'd3, 18'd1, 18'd0, 18'd0};
        vb = '{18'd4, 18'd1, 18'd0, 18'd0};
        run_dot(2, 1'b1, 0, 48'hFFFF_FFFF_FFF3, cc);
        wait_res();

        // Zero-length command: result next cycle, slice untouched
        run_dot(0, 1'b0, 0, 48'd0, cc);
        o_q.push_back('{cc + 1, 8'h08});
        o_q.push_back('{cc + 2, 8'h08});
        @(negedge CLK);
        chk("len0_in_ready", bus.in_ready, 1'b0);
        chk("len0_res_valid", bus.res_valid, 1'b1);
        @(posedge CLK); #1;
        wait_res();

        // Result back-pressure: 10*10 + 3*3 = 109 held while a new command waits
        bus.res_ready = 1'b0;
        va = '{18'd10, 18'd3, 18'd0, 18'd0};
        vb = '{18'd10, 18'd3, 18'd0, 18'd0};
        run_dot(2, 1'b0, 0, 48'd109, cc);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.res_valid) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) fail_now("stall_res_valid");
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(1);
        bus.cmd_sub   = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge CLK);
            chk("stall_res_valid", bus.res_valid, 1'b1);
            chk("stall_res_data", bus.res_data, 48'd109);
            chk("stall_cmd_ready", bus.cmd_ready, 1'b0);
        end
        @(posedge CLK); #1;
        rel_c = cyc;
        bus.res_ready = 1'b1;
        va = '{18'd6, 18'd0, 18'd0, 18'd0};
        vb = '{18'd6, 18'd0, 18'd0, 18'd0};
        run_dot(1, 1'b0, 0, 48'd36, cc);
        chk("cmd_after_result", cc, rel_c + 1);
        wait_res();

        // Reset in the middle of a 4-beat command, then a fresh 6*7
        send_cmd(LEN_W'(4), 1'b0, cc);
        send_beat(18'd9, 18'd9, 0, cc);
        send_beat(18'd5, 18'd5, 0, cc);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_opmode", DSP_OPMODE, 8'h00);
        chk("midrst_in_ready", bus.in_ready, 1'b0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("midrst_res_valid", bus.res_valid, 1'b0);
        @(posedge CLK); #1;
        va = '{18'd6, 18'd0, 18'd0, 18'd0};
        vb = '{18'd7, 18'd0, 18'd0, 18'd0};
        run_dot(1, 1'b0, 0, 48'd42, cc);
        wait_res();

        repeat (4) @(posedge CLK);
        chk("res_q_drained", res_q.size(), 0);
        chk("a_q_drained", a_q.size(), 0);
        chk("o_q_drained", o_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
Controller that drives one DSP48A1-style slice as a streaming multiply-accumulate (dot-product) engine. It accepts a command (length, add/sub), streams operand pairs from a valid/ready source onto the slice A/B ports, and generates a per-beat OPMODE aligned to the slice pipeline. It captures P after pipeline drain and returns the result over a valid/ready port. Sits between the sample/coefficient fetch logic and the slice instance.

Parameters:
LEN_W, 10, width of command length field (max LEN_W'((1<<LEN_W)-1) beats)
P_LAT, 3, cycles from operands on DSP_A/DSP_B to matching value on DSP_P (A1REG+MREG+PREG of slice)
OPM_DLY, 1, cycles the OPMODE for a beat lags its operands on the sequencer outputs (MREG+A1REG-OPMODEREG)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_len  in  LEN_W  number of beats, 0 allowed
cmd_sub  in  1  0: P accumulates +A*B; 1: P accumulates -A*B
in_valid  in  1  operand beat offered
in_ready  out  1  beat accepted when both high
in_a  in  18  unsigned operand A
in_b  in  18  unsigned operand B
DSP_A  out  18  to slice A
DSP_B  out  18  to slice B
DSP_OPMODE  out  8  to slice OPMODE
DSP_CE  out  1  clock enable for all slice registers
DSP_P  in  48  from slice P
res_valid  out  1  result available
res_ready  in  1  result consumed when both high
res_data  out  48  accumulated result, mod 2^48

Behaviour:
- Fixed to slice config B_INPUT=DIRECT, CARRYINSEL=OPMODE5; OPMODE[6:4]=000 always (no pre-adder, carry 0).
- Per-beat tag -> OPMODE: FIRST = {cmd_sub,3'b000,2'b00,2'b01} (Z=0,X=M); ACC = {cmd_sub,3'b000,2'b10,2'b01} (Z=P,X=M); HOLD = 8'h08 (Z=P,X=0, P unchanged); CLR = 8'h00.
- Every cycle the sequencer issues exactly one tag; the tag enters an OPM_DLY-deep delay line whose output is DSP_OPMODE. OPM_DLY=0 means a direct register-free path from the issue tag.
- DSP_A/DSP_B registered: beat accepted in cycle t appears during t+1; non-accept cycles drive 0 with tag HOLD.
- DSP_CE = 1 whenever not in reset (stalls handled by HOLD bubbles, not CE).
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: cmd_ready=1, in_ready=0, issue HOLD. On cmd handshake latch len, sub; len=0 -> DONE with res_data=0 next cycle (no slice activity); else -> RUN, beat counter=0.
- RUN: in_ready=1, cmd_ready=0. Accepted beat issues FIRST if counter=0 else ACC; counter++. Cycle with in_valid=0 issues HOLD, counter unchanged. Acceptance of beat number len-1 -> DRAIN, drain counter loaded P_LAT.
- DRAIN: in_ready=0, issue HOLD; counter decrements each cycle; when it reaches 0 (cycle in which last beat's P is on DSP_P, i.e. last accept t -> cycle t+1+P_LAT) register DSP_P into res_data -> DONE.
- DONE: res_valid=1, res_data stable until res_ready; on handshake -> IDLE. cmd_valid ignored in DONE (accepted earliest the cycle after returning to IDLE).
- Reset (any state, incl. mid-RUN/DRAIN): state IDLE, counters 0, cmd_ready=1 from first cycle after reset, in_ready=0, res_valid=0, res_data=0, DSP_A=DSP_B=0, delay line and DSP_OPMODE=CLR (8'h00, clears slice P next pass). In-flight beats discarded.
- Width: counters LEN_W bits; no overflow check on accumulation (wrap mod 2^48).

Decomposition:
- Package dsp_mac_pkg: state enum, OPMODE constants (OPM_FIRST_ADD, OPM_ACC_ADD, OPM_HOLD, OPM_CLR), sub-bit index.
- One sub-module: opmode_delay_line (parameter DEPTH, WIDTH=8, sync reset to 0, DEPTH=0 is pass-through).

Test Plan:
- Reset then len=3 add, beats (2,3),(4,5),(1,7) back-to-back -> DSP_OPMODE sequence 01,09,09 lagging DSP_A by OPM_DLY; res_data=33, res_valid 1+P_LAT cycles after last accept +1.
- Same command with in_valid gaps of 2 cycles between beats -> HOLD (08) bubbles inserted, res_data=33 unchanged.
- len=2 sub, beats (3,4),(1,1) -> res_data=48'hFFFF_FFFF_FFF3.
- len=0 -> res_valid next cycle after accept, res_data=0, DSP_OPMODE stays 08, no in_ready.
- res_ready held low 5 cycles in DONE -> res_valid/res_data stable, cmd_ready=0; second cmd offered, accepted only after result handshake.
- RST asserted mid-RUN after 2 of 4 beats -> next cycle IDLE, DSP_OPMODE=00, in_ready=0; new len=1 (6,7) yields 42.
